// File: rtl/mod6_sequence_monitor.sv
// mod6_sequence_monitor
// Watches a MOD-6 counter output, turns each legal 5->0 wrap into a one-cycle
// carry, and accumulates those carries in a cascaded mod-TENS_MOD digit.
// Illegal codes (6/7) and illegal jumps latch a sticky fault until ERR_CLR.
//
// Optional build macro: MOD6_MON_ERRCNT_EN adds ERR_CNT, an 8-bit saturating
// count of fault entries (cleared only by CLR).
//
// Handshake: there is no valid/ready pair; every EN=1 rising edge is one
// sample of Q_IN/LC_IN, and EN=0 stalls the monitor with CO forced low.
module mod6_sequence_monitor #(
    parameter int TENS_MOD = 10,
    parameter int TENS_W   = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    input  logic [2:0]        Q_IN,
    input  logic              LC_IN,
    input  logic              ERR_CLR,
    output logic              CO,
    output logic [TENS_W-1:0] TENS,
    output logic              TC,
    output logic              ERR,
`ifdef MOD6_MON_ERRCNT_EN
    output logic [7:0]        ERR_CNT,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [2:0]          prev_q, prev_nxt;
    logic                co_q, co_nxt;
    logic [TENS_W-1:0]   tens_q, tens_nxt;

    logic                q_ok;
    logic                step_legal;
    logic                wrap;

    // Step classification against the previously sampled code
    always_comb begin
        q_ok       = (Q_IN <= 3'd5);
        wrap       = !LC_IN && (prev_q == 3'd5) && (Q_IN == 3'd0);
        step_legal = q_ok && (LC_IN
                              || (Q_IN == prev_q)
                              || ((prev_q < 3'd5) && (Q_IN == prev_q + 3'd1))
                              || ((prev_q == 3'd5) && (Q_IN == 3'd0)));
    end

    // Next-state, next-carry and next-digit logic; everything holds when EN=0
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev_q;
        co_nxt    = 1'b0;
        tens_nxt  = tens_q;
        if (EN) begin
            case (state)
                ST_IDLE: begin
                    prev_nxt = Q_IN;
                    if (q_ok) state_nxt = ST_TRACK;
                    else      state_nxt = ST_FAULT;
                end
                ST_TRACK: begin
                    prev_nxt = Q_IN;
                    if (step_legal) begin
                        if (wrap) begin
                            co_nxt   = 1'b1;
                            tens_nxt = (tens_q == TENS_W'(TENS_MOD - 1))
                                       ? '0 : tens_q + TENS_W'(1);
                        end
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    // Acknowledge beats any illegal code on the same edge;
                    // IDLE re-checks Q_IN on the following edge.
                    if (ERR_CLR) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, history, carry and digit registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= ST_IDLE;
            prev_q <= 3'd0;
            co_q   <= 1'b0;
            tens_q <= '0;
        end else begin
            state  <= state_nxt;
            prev_q <= prev_nxt;
            co_q   <= co_nxt;
            tens_q <= tens_nxt;
        end
    end

`ifdef MOD6_MON_ERRCNT_EN
    logic       fault_entry;
    logic [7:0] err_cnt_q;

    assign fault_entry = EN && (state != ST_FAULT) && (state_nxt == ST_FAULT);

    // Saturating count of entries into FAULT; ERR_CLR does not touch it
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)                                   err_cnt_q <= 8'd0;
        else if (fault_entry && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign ERR_CNT = err_cnt_q;
`endif

    assign CO        = co_q;
    assign TENS      = tens_q;
    assign ERR       = (state == ST_FAULT);
    assign TC        = (state == ST_TRACK) && (tens_q == TENS_W'(TENS_MOD - 1))
                       && (Q_IN == 3'd5);
    assign dbg_state = state;

endmodule
